pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC and sequences instruction fetch. It is the consumer of the branch unit's redirect outputs (PcSel, BrPC).
- Issues fetch requests to instruction memory and advances PC+4 on grant. It applies taken branches and jumps, and buffers a redirect that arrives during a stall so the redirect is never lost.
- Pulses a one-cycle pipeline flush whenever a redirect is applied.

Parameters:
- PC_W, 9: width of the PC and of the instruction-memory byte address.
- RESET_PC, 0: PC value loaded on reset, PC_W bits.
- CNT_W, 16: width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard stall; PC must hold while high.
- pc_sel_i  in  1  redirect request from the branch unit (1 = branch taken or jump).
- br_pc_i  in  32  redirect target from the branch unit.
- imem_gnt_i  in  1  instruction memory accepted the current request.
- pc_o  out  PC_W  current fetch address.
- imem_req_o  out  1  fetch request valid.
- flush_o  out  1  one-cycle flush of the IF/ID and ID/EX registers.
- misalign_o  out  1  sticky flag: a redirect target had br_pc_i[1:0] != 0.
- redirect_cnt_o  out  CNT_W  count of applied redirects, saturating.

Behaviour:
- Reset (async assert, sync release):
  - pc_o = RESET_PC, imem_req_o = 0, flush_o = 0, misalign_o = 0, redirect_cnt_o = 0.
  - State = IDLE; pending-target register cleared.
- States: IDLE, FETCH, STALL, REDIR_PEND. All outputs are registered except imem_req_o, which is decoded as state == FETCH.
- IDLE: exactly one cycle after reset release, then FETCH. Inputs are ignored in IDLE.
- FETCH, evaluated each rising edge, in priority order:
  1. stall_i & pc_sel_i: capture br_pc_i into the pending register, go to REDIR_PEND, hold PC.
  2. stall_i: go to STALL, hold PC.
  3. pc_sel_i: pc_o <= {br_pc_i[PC_W-1:2], 2'b00}, flush_o <= 1 next cycle, increment counter. This applies even if imem_gnt_i = 0; the outstanding request is abandoned.
  4. imem_gnt_i: pc_o <= pc_o + 4, modulo 2^PC_W. Wrap from 2^PC_W-4 to 0 is legal and silent.
  5. Otherwise hold. pc_o must remain stable while imem_req_o=1 and imem_gnt_i=0, except on case 3.
- STALL: imem_req_o = 0, PC held.
  - pc_sel_i & stall_i: capture target, go to REDIR_PEND.
  - pc_sel_i & ~stall_i: apply redirect as in FETCH case 3, go to FETCH.
  - ~stall_i: go to FETCH.
- REDIR_PEND: imem_req_o = 0, PC held.
  - A new pc_sel_i overwrites the pending target; the newest target wins.
  - When stall_i = 0: pc_o <= pending target (low 2 bits cleared), flush pulse, increment counter, go to FETCH. If pc_sel_i is also high in that cycle, br_pc_i wins over the pending value.
- flush_o: high for exactly one cycle, the same cycle pc_o first shows the new target. Never high two consecutive cycles unless two redirects are applied on consecutive edges.
- misalign_o:
  - Set when a captured or applied target has br_pc_i[1:0] != 0. Cleared only by reset.
  - The redirect still proceeds using the aligned address.
- Target truncation: br_pc_i bits above PC_W-1 are ignored.
- redirect_cnt_o: +1 per applied redirect (not per capture). Saturates at all-ones.
- Reset asserted mid-operation: all state returns to reset values immediately and any pending redirect is discarded.

Test Plan:
- Reset release with imem_gnt_i held at 1, no stall or redirect -> cycle 1 IDLE (req=0, pc=0x000); then pc = 0x000, 0x004, 0x008, …; after pc = 0x1FC the next pc = 0x000 (wrap, PC_W=9).
- In FETCH at pc=0x010, pc_sel_i=1, br_pc_i=0x0000_0040, imem_gnt_i=0 -> next cycle pc_o=0x040, flush_o=1 for one cycle, redirect_cnt_o=1.
- stall_i=1 for 3 cycles with pc_sel_i=1, br_pc_i=0x080 in the first stall cycle -> pc and req=0 held throughout, flush_o=0; first cycle after stall drops: pc_o=0x080, flush_o=1, counter +1.
- In REDIR_PEND, a second pc_sel_i with br_pc_i=0x0C0 before the stall ends -> pc_o becomes 0x0C0 (not the first target) and the counter increments by exactly 1.
- pc_sel_i=1, br_pc_i=0x0000_0046 -> pc_o=0x044 and misalign_o=1, which stays 1 through subsequent normal fetches until reset_n=0.
- reset_n asserted while in REDIR_PEND, then released -> all outputs at reset values, pending target discarded, fetch restarts at RESET_PC after one IDLE cycle. A separate run with CNT_W=2 and 5 redirects gives redirect_cnt_o=3.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: issues fetch requests, advances PC+4 on grant,
// applies branch/jump redirects and buffers any redirect that arrives while stalled.
module pc_fetch_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             pc_sel_i,
    input  logic [31:0]      br_pc_i,
    input  logic             imem_gnt_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             imem_req_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        REDIR_PEND
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pend_pc, pend_nxt, pc_nxt;
    logic [PC_W-1:0] br_aligned;
    logic            br_misaligned;
    logic            apply;
    logic            mis_event;
    logic            unused_br_hi;

    // Targets beyond the PC width are truncated; the low two bits only feed misalign.
    assign br_aligned    = {br_pc_i[PC_W-1:2], 2'b00};
    assign br_misaligned = |br_pc_i[1:0];
    assign unused_br_hi  = ^br_pc_i[31:PC_W];

    assign imem_req_o = (state == FETCH);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_nxt = state;
        pc_nxt    = pc_o;
        pend_nxt  = pend_pc;
        apply     = 1'b0;
        mis_event = 1'b0;
        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH, STALL: begin
                if (stall_i && pc_sel_i) begin
                    pend_nxt  = br_aligned;
                    mis_event = br_misaligned;
                    state_nxt = REDIR_PEND;
                end else if (stall_i) begin
                    state_nxt = STALL;
                end else if (pc_sel_i) begin
                    // A redirect abandons any request that has not been granted yet.
                    pc_nxt    = br_aligned;
                    apply     = 1'b1;
                    mis_event = br_misaligned;
                    state_nxt = FETCH;
                end else begin
                    if (state == FETCH && imem_gnt_i) begin
                        pc_nxt = pc_o + PC_W'(4);
                    end
                    state_nxt = FETCH;
                end
            end
            REDIR_PEND: begin
                if (pc_sel_i) begin
                    pend_nxt  = br_aligned;
                    mis_event = br_misaligned;
                end
                if (!stall_i) begin
                    // The newest target wins, including one arriving on the release cycle.
                    pc_nxt    = pc_sel_i ? br_aligned : pend_pc;
                    apply     = 1'b1;
                    pend_nxt  = '0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pc_o           <= RESET_PC;
            pend_pc        <= '0;
            flush_o        <= 1'b0;
            misalign_o     <= 1'b0;
            redirect_cnt_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state   <= state_nxt;
            pc_o    <= pc_nxt;
            pend_pc <= pend_nxt;
            flush_o <= apply;
            if (mis_event) begin
                misalign_o <= 1'b1;
            end
            if (apply && (redirect_cnt_o != '1)) begin
                redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan steps followed by random
// traffic, compared every cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            stall_i = 1'b0;
    logic            pc_sel_i = 1'b0;
    logic [31:0]     br_pc_i = '0;
    logic            imem_gnt_i = 1'b0;
    logic [PC_W-1:0] pc_o, pc_b;
    logic            imem_req_o, req_b;
    logic            flush_o, flush_b;
    logic            misalign_o, mis_b;
    logic [15:0]     redirect_cnt_o;
    logic [1:0]      cnt_b;

    pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .pc_sel_i(pc_sel_i),
        .br_pc_i(br_pc_i), .imem_gnt_i(imem_gnt_i), .pc_o(pc_o),
        .imem_req_o(imem_req_o), .flush_o(flush_o), .misalign_o(misalign_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    // Narrow-counter copy driven identically, used to observe saturation.
    pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .pc_sel_i(pc_sel_i),
        .br_pc_i(br_pc_i), .imem_gnt_i(imem_gnt_i), .pc_o(pc_b),
        .imem_req_o(req_b), .flush_o(flush_b), .misalign_o(mis_b),
        .redirect_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: flags describing what the fetcher is doing, not an encoding.
    bit              m_idle, m_stalled, m_has_pend, m_flush, m_mis;
    logic [PC_W-1:0] m_pc, m_pend;
    int              m_cnt;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_stalled = 0; m_has_pend = 0; m_flush = 0; m_mis = 0;
        m_pc = '0; m_pend = '0; m_cnt = 0;
    endtask

    task automatic model_redirect(logic [31:0] target);
        m_pc    = target[PC_W-1:0] & ~(PC_W'(3));
        m_flush = 1;
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic model_edge();
        bit odd;
        odd     = (br_pc_i[1:0] != 2'b00);
        m_flush = 0;
        if (m_idle) begin
            m_idle = 0;
        end else if (m_has_pend) begin
            if (pc_sel_i) begin
                m_pend = br_pc_i[PC_W-1:0] & ~(PC_W'(3));
                if (odd) m_mis = 1;
            end
            if (!stall_i) begin
                model_redirect({23'd0, m_pend});
                m_has_pend = 0;
            end
        end else if (stall_i && pc_sel_i) begin
            m_pend = br_pc_i[PC_W-1:0] & ~(PC_W'(3));
            if (odd) m_mis = 1;
            m_has_pend = 1;
            m_stalled  = 0;
        end else if (stall_i) begin
            m_stalled = 1;
        end else if (pc_sel_i) begin
            model_redirect(br_pc_i);
            if (odd) m_mis = 1;
            m_stalled = 0;
        end else begin
            if (!m_stalled && imem_gnt_i) m_pc = m_pc + PC_W'(4);
            m_stalled = 0;
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".pc"},    32'(pc_o), 32'(m_pc));
        check({tag, ".req"},   32'(imem_req_o), 32'(!m_idle && !m_stalled && !m_has_pend));
        check({tag, ".flush"}, 32'(flush_o), 32'(m_flush));
        check({tag, ".mis"},   32'(misalign_o), 32'(m_mis));
        check({tag, ".cnt"},   32'(redirect_cnt_o), 32'(m_cnt));
        check({tag, ".cnt2"},  32'(cnt_b), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    endtask

    task automatic step(string tag, bit s, bit p, logic [31:0] b, bit g);
        stall_i = s; pc_sel_i = p; br_pc_i = b; imem_gnt_i = g;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        #1 reset_n = 1'b0;
        #1 model_reset();
        check_all({tag, ".async"});
        @(negedge clk);
        reset_n = 1'b1;
        check_all({tag, ".idle"});
    endtask

    initial begin
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;
        check_all("por_idle");

        // Free-running fetch with permanent grant, through the PC wrap.
        step("idle_exit", 0, 0, 32'h0, 1);
        check("first_fetch_pc", 32'(pc_o), 32'h000);
        for (int i = 0; i < 128; i++) step("seq", 0, 0, 32'h0, 1);
        check("wrap_pc", 32'(pc_o), 32'h000);
        while (m_pc != PC_W'(9'h010)) step("to_010", 0, 0, 32'h0, 1);

        // Redirect without grant.
        step("redir", 0, 1, 32'h0000_0040, 0);
        check("redir_pc", 32'(pc_o), 32'h040);
        check("redir_flush", 32'(flush_o), 32'h1);
        step("redir_after", 0, 0, 32'h0, 0);
        check("flush_one_cycle", 32'(flush_o), 32'h0);

        // Redirect captured during a 3-cycle stall.
        step("stall1", 1, 1, 32'h0000_0080, 1);
        step("stall2", 1, 0, 32'h0, 1);
        step("stall3", 1, 0, 32'h0, 1);
        step("stall_rel", 0, 0, 32'h0, 1);
        check("stall_redir_pc", 32'(pc_o), 32'h080);

        // Newer target overwrites pending one.
        step("pend1", 1, 1, 32'h0000_0080, 1);
        step("pend2", 1, 1, 32'h0000_00C0, 1);
        step("pend3", 1, 0, 32'h0, 1);
        step("pend_rel", 0, 0, 32'h0, 1);
        check("newest_pc", 32'(pc_o), 32'h0C0);
        check("newest_cnt", 32'(redirect_cnt_o), 32'd3);

        // Misaligned target is aligned and the flag sticks.
        step("mis", 0, 1, 32'h0000_0046, 1);
        check("mis_pc", 32'(pc_o), 32'h044);
        for (int i = 0; i < 4; i++) step("mis_hold", 0, 0, 32'h0, 1);
        check("mis_sticky", 32'(misalign_o), 32'h1);

        // Reset while a redirect is pending.
        step("pend_rst", 1, 1, 32'h0000_0100, 1);
        do_reset("rst_pend");
        step("rst_restart", 0, 0, 32'h0, 1);
        check("restart_pc", 32'(pc_o), 32'h000);

        // Five redirects against the 2-bit counter copy.
        for (int i = 0; i < 5; i++) step("sat", 0, 1, 32'(i * 16 + 32'h0001_0020), 0);
        check("sat_cnt2", 32'(cnt_b), 32'd3);
        check("sat_cnt16", 32'(redirect_cnt_o), 32'd5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
